// File: rtl/oob_pkg.sv
// Shared state encoding and parameter defaults for the SATA/GTX OOB sequencer.
package oob_pkg;

    localparam int DEF_TIMEOUT_CYCLES = 16384;
    localparam int DEF_HOLD_CYCLES    = 5;
    localparam int DEF_MAX_RETRIES    = 3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEND_INIT,
        S_WAIT_INIT,
        S_SEND_WAKE,
        S_WAIT_WAKE,
        S_HOLD,
        S_WAIT_ALIGN,
        S_LINK,
        S_ERROR
    } oob_state_e;

endpackage

// File: rtl/oob_sequencer_if.sv
// OOB control/status bundle between the sequencer (master) and the GTX channel side (slave).
interface oob_sequencer_if;

    logic       en;
    logic       txcomfinish;
    logic       rxcominitdet;
    logic       rxcomwakedet;
    logic       rxbyteisaligned;
    logic       txelecidle;
    logic       txcominit;
    logic       txcomwake;
    logic       link_up;
    logic       err;
    logic [3:0] retry_cnt;

    modport master (
        input  en, txcomfinish, rxcominitdet, rxcomwakedet, rxbyteisaligned,
        output txelecidle, txcominit, txcomwake, link_up, err, retry_cnt
    );

    modport slave (
        output en, txcomfinish, rxcominitdet, rxcomwakedet, rxbyteisaligned,
        input  txelecidle, txcominit, txcomwake, link_up, err, retry_cnt
    );

endinterface

// File: rtl/oob_timer.sv
// 16-bit loadable down-counter; expired_o is high in the last cycle of a loaded interval,
// so a load of N gives exactly N cycles in the owning state.
module oob_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    output logic        expired_o
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == 16'd1);

endmodule

// File: rtl/oob_sequencer.sv
// COMINIT/COMWAKE out-of-band handshake for a GTXE2 channel; all outputs registered from next state,
// so they track the state one cycle after the causing input. No backpressure: the partner sets the pace.
module oob_sequencer
    import oob_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic            clk,
    input  logic            reset,
    oob_sequencer_if.master bus
);

    oob_state_e  state_q, state_d, retry_tgt;
    logic        fin_q, fin_d, det_q, det_d, det_in, in_flag_wait;
    logic        txelecidle_q, txelecidle_d;
    logic        txcominit_q, txcominit_d;
    logic        txcomwake_q, txcomwake_d;
    logic        link_up_q, link_up_d;
    logic        err_q, err_d;
    logic [3:0]  retry_cnt_q, retry_cnt_d;
    logic        tmr_load, tmr_expired;
    logic [15:0] tmr_load_val;

    oob_timer u_timer (
        .clk        (clk),
        .rst        (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .expired_o  (tmr_expired)
    );

    always_comb begin
        in_flag_wait = (state_q == S_WAIT_INIT) || (state_q == S_WAIT_WAKE);
        det_in       = (state_q == S_WAIT_INIT) ? bus.rxcominitdet : bus.rxcomwakedet;
        fin_d        = in_flag_wait && (fin_q || bus.txcomfinish);
        det_d        = in_flag_wait && (det_q || det_in);
        retry_tgt    = (retry_cnt_q < 4'(MAX_RETRIES)) ? S_SEND_INIT : S_ERROR;

        state_d = state_q;
        unique case (state_q)
            S_IDLE:       if (bus.en) state_d = S_SEND_INIT;
            S_SEND_INIT:  state_d = S_WAIT_INIT;
            // Both flags already registered means this is the gap cycle; once seen, the timer is ignored.
            S_WAIT_INIT: begin
                if (fin_q && det_q)              state_d = S_SEND_WAKE;
                else if (!(fin_d && det_d) && tmr_expired) state_d = retry_tgt;
            end
            S_SEND_WAKE:  state_d = S_WAIT_WAKE;
            S_WAIT_WAKE: begin
                if (fin_d && det_d)      state_d = S_HOLD;
                else if (tmr_expired)    state_d = retry_tgt;
            end
            S_HOLD:       if (tmr_expired) state_d = S_WAIT_ALIGN;
            S_WAIT_ALIGN: begin
                if (bus.rxbyteisaligned) state_d = S_LINK;
                else if (tmr_expired)    state_d = retry_tgt;
            end
            S_LINK:       if (bus.rxcominitdet) state_d = S_SEND_INIT;
            S_ERROR:      state_d = S_ERROR;
            default:      state_d = S_IDLE;
        endcase
        if (!bus.en) state_d = S_IDLE;

        tmr_load     = (state_d != state_q) &&
                       (state_d inside {S_WAIT_INIT, S_WAIT_WAKE, S_HOLD, S_WAIT_ALIGN});
        tmr_load_val = (state_d == S_HOLD) ? 16'(HOLD_CYCLES) : 16'(TIMEOUT_CYCLES);

        retry_cnt_d = retry_cnt_q;
        if (state_d == S_IDLE) begin
            retry_cnt_d = '0;
        end else if (state_d == S_SEND_INIT) begin
            // A partner reset from LINK starts a fresh sequence: cleared, then this attempt counted.
            if (state_q == S_LINK)          retry_cnt_d = 4'd1;
            else if (retry_cnt_q != 4'hF)   retry_cnt_d = retry_cnt_q + 4'd1;
        end

        txelecidle_d = !((state_d == S_WAIT_ALIGN) || (state_d == S_LINK));
        txcominit_d  = (state_d == S_SEND_INIT);
        txcomwake_d  = (state_d == S_SEND_WAKE);
        link_up_d    = (state_d == S_LINK);

        err_d = err_q;
        if (state_d == S_ERROR)     err_d = 1'b1;
        else if (state_d == S_IDLE) err_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            fin_q        <= 1'b0;
            det_q        <= 1'b0;
            txelecidle_q <= 1'b1;
            txcominit_q  <= 1'b0;
            txcomwake_q  <= 1'b0;
            link_up_q    <= 1'b0;
            err_q        <= 1'b0;
            retry_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            fin_q        <= fin_d;
            det_q        <= det_d;
            txelecidle_q <= txelecidle_d;
            txcominit_q  <= txcominit_d;
            txcomwake_q  <= txcomwake_d;
            link_up_q    <= link_up_d;
            err_q        <= err_d;
            retry_cnt_q  <= retry_cnt_d;
        end
    end

    assign bus.txelecidle = txelecidle_q;
    assign bus.txcominit  = txcominit_q;
    assign bus.txcomwake  = txcomwake_q;
    assign bus.link_up    = link_up_q;
    assign bus.err        = err_q;
    assign bus.retry_cnt  = retry_cnt_q;

endmodule

// File: tb/tb_oob_sequencer.sv
// Randomized OOB scenarios; a reactive partner answers pulses, expected event cycles come from timing arithmetic.
module tb_oob_sequencer;

    localparam int T = 100;
    localparam int H = 5;
    localparam int M = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    oob_sequencer_if bus();

    oob_sequencer #(.TIMEOUT_CYCLES(T), .HOLD_CYCLES(H), .MAX_RETRIES(M)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    int init_q[$];
    int wake_q[$];
    int fall_t, link_t, err_t, retry_link, retry_err, viol;
    logic prev_init, prev_wake;
    int cfg_nf, cfg_df, cfg_dd, cfg_wf, cfg_wd, cfg_da;
    int fin_at, det_at, wfin_at, wdet_at, align_at, lrst_at;

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_sched();
        fin_at = -1; det_at = -1; wfin_at = -1; wdet_at = -1; align_at = -1; lrst_at = -1;
    endtask

    task automatic reset_mon();
        init_q.delete();
        wake_q.delete();
        fall_t = -1; link_t = -1; err_t = -1; retry_link = -1; retry_err = -1; viol = 0;
        prev_init = 1'b0; prev_wake = 1'b0;
    endtask

    // Partner: inputs for the current cycle, from schedules set when pulses were seen.
    task automatic drive_partner();
        bus.txcomfinish     = (cyc == fin_at) || (cyc == wfin_at);
        bus.rxcominitdet    = (cyc == det_at) || (cyc == lrst_at);
        bus.rxcomwakedet    = (cyc == wdet_at);
        bus.rxbyteisaligned = (align_at >= 0) && (cyc >= align_at);
    endtask

    task automatic sample();
        if (bus.txcominit) begin
            init_q.push_back(cyc);
            fin_at = cyc + cfg_df;
            det_at = (init_q.size() > cfg_nf) ? cyc + cfg_dd : -1;
        end
        if (bus.txcomwake) begin
            wake_q.push_back(cyc);
            wfin_at = cyc + cfg_wf;
            wdet_at = cyc + cfg_wd;
        end
        if (!bus.txelecidle && fall_t < 0) begin
            fall_t   = cyc;
            align_at = cyc + cfg_da;
        end
        if (bus.link_up && link_t < 0) begin
            link_t     = cyc;
            retry_link = int'(bus.retry_cnt);
        end
        if (bus.err && err_t < 0) begin
            err_t     = cyc;
            retry_err = int'(bus.retry_cnt);
        end
        if ((bus.txcominit && bus.txcomwake) || (bus.txcominit && prev_init) ||
            (bus.txcomwake && prev_wake))
            viol++;
        prev_init = bus.txcominit;
        prev_wake = bus.txcomwake;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        drive_partner();
        @(negedge clk);
        sample();
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, ":txelecidle"}, int'(bus.txelecidle), 1);
        check_val({tag, ":txcominit"},  int'(bus.txcominit),  0);
        check_val({tag, ":txcomwake"},  int'(bus.txcomwake),  0);
        check_val({tag, ":link_up"},    int'(bus.link_up),    0);
        check_val({tag, ":err"},        int'(bus.err),        0);
        check_val({tag, ":retry_cnt"},  int'(bus.retry_cnt),  0);
    endtask

    // mode 0: run to link/error; 1: partner reset in link; 2: en=0 at c0+abk; 3: reset at c0+abk
    task automatic run_scn(input int nf, input int df, input int dd, input int wf, input int wd,
                           input int da, input int mode, input int abk);
        int c0, p, x, w, y, fall, lnk, n0, w0, budget, r;
        reset_mon();
        clear_sched();
        cfg_nf = nf; cfg_df = df; cfg_dd = dd; cfg_wf = wf; cfg_wd = wd; cfg_da = da;
        c0 = cyc;
        bus.en = 1'b1;
        if (mode >= 2) begin
            while (cyc < c0 + abk) tick();
            bus.en = 1'b0;
            clear_sched();
            if (mode == 2) begin
                tick();
                check_idle("abort_en");
            end else begin
                reset = 1'b1;
                #1;
                check_idle("abort_rst");
                tick();
                tick();
                reset = 1'b0;
            end
            n0 = init_q.size();
            w0 = wake_q.size();
            repeat (20) tick();
            check_val("stray_init", init_q.size() - n0, 0);
            check_val("stray_wake", wake_q.size() - w0, 0);
            check_val("proto", viol, 0);
        end else begin
            p      = c0 + 1 + nf * (T + 1);
            budget = c0 + 700;
            while (cyc < budget && link_t < 0 && err_t < 0) tick();
            check_val("n_init", init_q.size(), (nf >= M) ? M : nf + 1);
            for (int k = 0; k < init_q.size() && k <= nf; k++)
                check_val("t_init", init_q[k], c0 + 1 + k * (T + 1));
            if (nf >= M) begin
                check_val("t_err", err_t, c0 + 1 + M * (T + 1));
                check_val("retry_err", retry_err, M);
                check_val("n_wake_err", wake_q.size(), 0);
            end else begin
                x    = p + ((df > dd) ? df : dd);
                w    = x + 2;
                y    = w + ((wf > wd) ? wf : wd);
                fall = y + H + 1;
                lnk  = fall + da + 1;
                check_val("n_wake", wake_q.size(), 1);
                if (wake_q.size() > 0) check_val("t_wake", wake_q[0], w);
                check_val("t_fall", fall_t, fall);
                check_val("t_link", link_t, lnk);
                check_val("retry_link", retry_link, nf + 1);
                if (mode == 1 && link_t >= 0) begin
                    r = cyc + 3;
                    lrst_at = r;
                    while (cyc < r + 1) tick();
                    check_val("prst_link_up",    int'(bus.link_up),    0);
                    check_val("prst_txelecidle", int'(bus.txelecidle), 1);
                    check_val("prst_txcominit",  int'(bus.txcominit),  1);
                    check_val("prst_retry_cnt",  int'(bus.retry_cnt),  1);
                end
            end
            check_val("proto", viol, 0);
            bus.en = 1'b0;
            clear_sched();
            tick();
            check_idle("en_off");
            repeat (4) tick();
        end
    endtask

    initial begin
        int nf, md;
        reset = 1'b1;
        bus.en = 1'b0;
        bus.txcomfinish = 1'b0;
        bus.rxcominitdet = 1'b0;
        bus.rxcomwakedet = 1'b0;
        bus.rxbyteisaligned = 1'b0;
        cfg_nf = 0; cfg_df = 1; cfg_dd = 1; cfg_wf = 1; cfg_wd = 1; cfg_da = 1;
        reset_mon();
        clear_sched();
        tick();
        tick();
        check_idle("reset");
        reset = 1'b0;
        repeat (3) tick();
        check_idle("post_reset");

        run_scn(0, 40, 60, 40, 60, 10, 0, 0);
        run_scn(0, 30, 30, 20, 20, 5, 0, 0);
        run_scn(3, 40, 60, 40, 60, 10, 0, 0);
        run_scn(0, 40, 60, 40, 60, 10, 1, 0);
        run_scn(0, 40, 60, 40, 60, 10, 3, 83);
        run_scn(0, 40, 60, 40, 60, 10, 2, 126);
        run_scn(1, T, T, T, T, T - 1, 0, 0);
        run_scn(2, 5, 90, 77, 3, 1, 0, 0);

        for (int i = 0; i < 16; i++) begin
            nf = $urandom_range(0, 3);
            md = $urandom_range(0, 3);
            if (nf == 3 && md == 1) md = 0;
            run_scn(nf, $urandom_range(1, T), $urandom_range(1, T), $urandom_range(1, T),
                    $urandom_range(1, T), $urandom_range(1, 40), md, $urandom_range(1, 260));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
